// File: rtl/rc_add_seq_pkg.sv
// Shared definitions for the rc_add_seq multi-cycle adder: state encoding and
// index-width helper.
package rc_add_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // A single-slice sequencer still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/rc_16b.sv
// 16-bit ripple-carry adder slice, the shared datapath reused by rc_add_seq.
module rc_16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        c_o
);

  logic [16:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int i = 0; i < 16; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = carry[16];

endmodule

// File: rtl/rc_add_seq.sv
// Multi-cycle WIDTH*WORDS-bit adder built from one WIDTH-bit ripple slice, LSB slice first.
// Optional subtract mode (sub port) when RC_ADD_SEQ_SUB_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// RUN    | one slice per clock, carry registered between slices
// DONE   | result held on sum/cout/ovf until out_ready
module rc_add_seq
  import rc_add_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   cin,
`ifdef RC_ADD_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;

  logic             sub_w;
  logic [N-1:0]     b_in;
  logic             c_in;
  logic [WIDTH-1:0] sl_a, sl_b, sl_s;
  logic             sl_c;

`ifdef RC_ADD_SEQ_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Subtraction is A + ~B + 1; the stored B is already inverted so ovf sees the effective operand.
  assign b_in = sub_w ? ~op_b : op_b;
  assign c_in = sub_w ? 1'b1 : cin;

  assign sl_a = a_q[idx_q*WIDTH +: WIDTH];
  assign sl_b = b_q[idx_q*WIDTH +: WIDTH];

  generate
    if (WIDTH == 16) begin : g_rc16
      rc_16b u_slice (
        .a_i (sl_a),
        .b_i (sl_b),
        .c_i (carry_q),
        .s_o (sl_s),
        .c_o (sl_c)
      );
    end else begin : g_generic
      assign {sl_c, sl_s} = {1'b0, sl_a} + {1'b0, sl_b} + {{WIDTH{1'b0}}, carry_q};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = op_a;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy                        = 1'b1;
        sum_d[idx_q*WIDTH +: WIDTH] = sl_s;
        carry_d                     = sl_c;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = carry_q;
  assign ovf  = (a_q[N-1] == b_q[N-1]) && (sum_q[N-1] != a_q[N-1]);

endmodule

// File: tb/tb_rc_add_seq.sv
// Scoreboard bench for rc_add_seq (WIDTH=16, WORDS=4); exercises sub mode when RC_ADD_SEQ_SUB_EN is defined.
module tb_rc_add_seq;

  localparam int WORDS = 4;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic        clk, rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [63:0] op_a, op_b, sum;
`ifdef RC_ADD_SEQ_SUB_EN
  logic        sub_r;
`endif

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rise_cyc = 0;
  int   busy_cnt = 0;
  logic prev_ov  = 1'b0;

  rc_add_seq #(.WIDTH(16), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef RC_ADD_SEQ_SUB_EN
    .sub       (sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: full-width unsigned sum for sum/cout, signed sum representability for ovf.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic s, input int acc);
    exp_t                r;
    logic [63:0]         bb;
    logic                cc;
    logic [64:0]         u;
    logic signed [65:0]  sv;
    bb = s ? ~b : b;
    cc = s ? 1'b1 : c;
    u  = {1'b0, a} + {1'b0, bb} + {64'd0, cc};
    sv = $signed({{2{a[63]}}, a}) + $signed({{2{bb[63]}}, bb}) + $signed({65'd0, cc});
    r.sum     = u[63:0];
    r.cout    = u[64];
    r.ovf     = (sv[65:63] != 3'b000) && (sv[65:63] != 3'b111);
    r.acc_cyc = acc;
    return r;
  endfunction

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
    int t = 0;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    cin      = c;
`ifdef RC_ADD_SEQ_SUB_EN
    sub_r    = s;
`endif
    while (!in_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    q.push_back(model(a, b, c, s, cyc));
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) check("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (out_valid && !prev_ov) begin
        rise_cyc = cyc;
        check("busy_cycles", 64'(busy_cnt), 64'(WORDS));
        busy_cnt = 0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.sum);
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf", 64'(ovf), 64'(e.ovf));
          check("latency", 64'(rise_cyc - e.acc_cyc), 64'(WORDS));
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    exp_t        ex;
    logic [63:0] ra, rb;
    logic        s;
    int          t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0;
    op_a = '0; op_b = '0;
`ifdef RC_ADD_SEQ_SUB_EN
    sub_r = 1'b0;
`endif
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
`ifdef RC_ADD_SEQ_SUB_EN
    send(64'd5, 64'd7, 1'b1, 1'b1);
    send(64'd7, 64'd5, 1'b0, 1'b1);
`endif

    // Backpressure: result must hold and no new request may be taken while out_ready is low.
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    ex = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 0);
    wait_valid();
    in_valid = 1'b1;
    op_a = 64'h0000_0001_0000_FFFF;
    op_b = 64'h0000_0002_0000_0001;
    cin  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum", sum, ex.sum);
      check("bp_cout_ovf", {62'd0, cout, ovf}, {62'd0, ex.cout, ex.ovf});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", 64'(in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(out_valid), 64'd0);
    send(64'h0000_0001_0000_FFFF, 64'h0000_0002_0000_0001, 1'b0, 1'b0);

    // Reset in the middle of RUN with slices already written.
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    send(64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    q.delete();
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", sum, 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    send(64'd3, 64'd4, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ra = {$urandom, $urandom};
        1: ra = ~rb;
        2: ra = 64'h7FFF_FFFF_FFFF_FFFF ^ 64'($urandom_range(0, 255));
        default: ra = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
`ifdef RC_ADD_SEQ_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      send(ra, rb, 1'($urandom_range(0, 1)), s);
    end

    t = 0;
    while (q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    check("drain_queue", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
